// File: rtl/alu_cargador_operandos_pkg.sv
// Shared definitions for the ALU operand loader: state encoding, flag bit
// positions inside the captured flag nibble, and control-byte field slices.
package alu_pkg;

  typedef enum logic [2:0] {
    ESPERA_A    = 3'd0,
    ESPERA_B    = 3'd1,
    ESPERA_CTRL = 3'd2,
    EJECUTA     = 3'd3,
    LISTO       = 3'd4
  } estado_t;

  // Flag nibble layout {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Control byte: [7:5] operation code, [4:0] shift amount
  localparam int CTRL_OP_HI   = 7;
  localparam int CTRL_OP_LO   = 5;
  localparam int CTRL_CANT_HI = 4;
  localparam int CTRL_CANT_LO = 0;

  function automatic logic [2:0] ctrl_op(input logic [7:0] b);
    return b[CTRL_OP_HI:CTRL_OP_LO];
  endfunction

  function automatic logic [4:0] ctrl_cant(input logic [7:0] b);
    return b[CTRL_CANT_HI:CTRL_CANT_LO];
  endfunction

endpackage

// File: rtl/alu_cargador_operandos_if.sv
// Byte-load port, ALU feedback and loader outputs bundled as one interface.
// master = stimulus/ALU side, slave = the loader itself.
interface alu_cargador_operandos_if;

  logic [7:0] data_in;
  logic       strobe;
  logic       cancel;
  logic [7:0] alu_resultado;
  logic       alu_carry;
  logic       alu_overflow;
  logic       alu_negative;
  logic       alu_zero;

  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] op_control;
  logic [4:0] op_cantidad;
  logic [7:0] res;
  logic [3:0] flags;
  logic       res_valid;
  logic       busy;
  logic       err;
  logic [7:0] n_ops;

  modport master (
    output data_in, strobe, cancel,
    output alu_resultado, alu_carry, alu_overflow, alu_negative, alu_zero,
    input  op_a, op_b, op_control, op_cantidad,
    input  res, flags, res_valid, busy, err, n_ops
  );

  modport slave (
    input  data_in, strobe, cancel,
    input  alu_resultado, alu_carry, alu_overflow, alu_negative, alu_zero,
    output op_a, op_b, op_control, op_cantidad,
    output res, flags, res_valid, busy, err, n_ops
  );

endinterface

// File: rtl/alu_cargador_operandos_timeout_cnt.sv
// Saturating idle-cycle counter. Counts while enabled, clears on request,
// and flags expiry in the cycle whose end would make the idle count reach
// LIMIT. LIMIT = 0 disables expiry.
module alu_timeout_cnt #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] TERM = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Idle count: clear has priority, otherwise count up and stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && en && !clr && (count == TERM);

endmodule

// File: rtl/alu_cargador_operandos.sv
// Operand loader for the 8-bit ALU stage: collects A, B and control bytes,
// holds them as ALU operands, captures the ALU result/flags one cycle later.
//
// state       | meaning
// ESPERA_A    | idle, next byte is operand A
// ESPERA_B    | A loaded, waiting for B (timeout armed)
// ESPERA_CTRL | B loaded, waiting for control byte (timeout armed)
// EJECUTA     | operands stable, ALU settling; capture at end of cycle
// LISTO       | result held, next byte starts a new transaction
module alu_cargador_operandos
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cargador_operandos_if.slave  bus
);

  estado_t    state, state_next;
  logic       load_a, load_b, load_c, capture, err_next;
  logic       cnt_en, cnt_clr, expired;

  logic [7:0] op_a_q, op_b_q, res_q, n_ops_q;
  logic [2:0] ctrl_q;
  logic [4:0] cant_q;
  logic [3:0] flags_q;
  logic       res_valid_q, err_q;

  // Any accepted byte or cancel restarts the idle count; it only runs while
  // a transaction is partially loaded.
  assign cnt_en  = (state == ESPERA_B) || (state == ESPERA_CTRL);
  assign cnt_clr = !cnt_en || bus.strobe || bus.cancel;

  alu_timeout_cnt #(
    .WIDTH (8),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ESPERA_A;
    end else begin
      state <= state_next;
    end
  end

  // Next state and load strobes; cancel outranks strobe, strobe outranks timeout
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_c     = 1'b0;
    capture    = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      ESPERA_A, LISTO: begin
        if (bus.strobe) begin
          load_a     = 1'b1;
          state_next = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (bus.cancel) begin
          state_next = ESPERA_A;
        end else if (bus.strobe) begin
          load_b     = 1'b1;
          state_next = ESPERA_CTRL;
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = ESPERA_A;
        end
      end
      ESPERA_CTRL: begin
        if (bus.cancel) begin
          state_next = ESPERA_A;
        end else if (bus.strobe) begin
          load_c     = 1'b1;
          state_next = EJECUTA;
        end else if (expired) begin
          err_next   = 1'b1;
          state_next = ESPERA_A;
        end
      end
      EJECUTA: begin
        capture    = 1'b1;
        err_next   = bus.strobe;
        state_next = LISTO;
      end
      default: begin
        state_next = ESPERA_A;
      end
    endcase
  end

  // Operand registers: each changes only when its own byte is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      ctrl_q <= '0;
      cant_q <= '0;
    end else begin
      if (load_a) op_a_q <= bus.data_in;
      if (load_b) op_b_q <= bus.data_in;
      if (load_c) begin
        ctrl_q <= ctrl_op(bus.data_in);
        cant_q <= ctrl_cant(bus.data_in);
      end
    end
  end

  // Result capture, operation counter and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      flags_q     <= '0;
      n_ops_q     <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= capture;
      err_q       <= err_next;
      if (capture) begin
        res_q          <= bus.alu_resultado;
        flags_q[FLAG_C] <= bus.alu_carry;
        flags_q[FLAG_V] <= bus.alu_overflow;
        flags_q[FLAG_N] <= bus.alu_negative;
        flags_q[FLAG_Z] <= bus.alu_zero;
        n_ops_q        <= n_ops_q + 8'd1;
      end
    end
  end

  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.op_control  = ctrl_q;
  assign bus.op_cantidad = cant_q;
  assign bus.res         = res_q;
  assign bus.flags       = flags_q;
  assign bus.n_ops       = n_ops_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state == EJECUTA);

endmodule

// File: tb/tb_alu_cargador_operandos.sv
// Self-checking bench for alu_cargador_operandos: vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_cargador_operandos;
  import alu_pkg::*;

  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_cargador_operandos_if bus();

  alu_cargador_operandos #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] m_a, m_b, m_res, m_nops;
  logic [2:0] m_ctrl;
  logic [4:0] m_cant;
  logic [3:0] m_flags;
  logic       m_rv, m_err, m_exec;
  int         m_idle;
  logic [7:0] pend[$];
  bit         chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_res = 0; m_nops = 0; m_ctrl = 0; m_cant = 0;
      m_flags = 0; m_rv = 0; m_err = 0; m_exec = 0; m_idle = 0;
      pend.delete();
    end else begin
      m_rv  = 1'b0;
      m_err = 1'b0;
      if (m_exec) begin
        m_res   = bus.alu_resultado;
        m_flags = {bus.alu_carry, bus.alu_overflow, bus.alu_negative, bus.alu_zero};
        m_nops  = m_nops + 8'd1;
        m_rv    = 1'b1;
        m_err   = bus.strobe;
        m_exec  = 1'b0;
      end else if (pend.size() == 0) begin
        if (bus.strobe) begin
          m_a = bus.data_in;
          pend.push_back(bus.data_in);
          m_idle = 0;
        end
      end else if (bus.cancel) begin
        pend.delete();
      end else if (bus.strobe) begin
        pend.push_back(bus.data_in);
        m_idle = 0;
        if (pend.size() == 2) begin
          m_b = bus.data_in;
        end else begin
          m_ctrl = bus.data_in[7:5];
          m_cant = bus.data_in[4:0];
          pend.delete();
          m_exec = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          pend.delete();
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("sb_op_a",   32'(bus.op_a),        32'(m_a));
      chk("sb_op_b",   32'(bus.op_b),        32'(m_b));
      chk("sb_ctrl",   32'(bus.op_control),  32'(m_ctrl));
      chk("sb_cant",   32'(bus.op_cantidad), 32'(m_cant));
      chk("sb_res",    32'(bus.res),         32'(m_res));
      chk("sb_flags",  32'(bus.flags),       32'(m_flags));
      chk("sb_rv",     32'(bus.res_valid),   32'(m_rv));
      chk("sb_err",    32'(bus.err),         32'(m_err));
      chk("sb_busy",   32'(bus.busy),        32'(m_exec));
      chk("sb_n_ops",  32'(bus.n_ops),       32'(m_nops));
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       strobe;
    logic       cancel;
    logic [7:0] data;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [2:0] e_ctrl;
    logic [4:0] e_cant;
    logic [7:0] e_res;
    logic [3:0] e_flags;
    logic       e_rv;
    logic       e_err;
    logic       e_busy;
    logic [7:0] e_nops;
    estado_t    e_st;
  } vec_t;

  vec_t tbl[10];

  task automatic check_all_zero(input string tag);
    chk({tag, "_op_a"},  32'(bus.op_a),        32'h0);
    chk({tag, "_op_b"},  32'(bus.op_b),        32'h0);
    chk({tag, "_ctrl"},  32'(bus.op_control),  32'h0);
    chk({tag, "_cant"},  32'(bus.op_cantidad), 32'h0);
    chk({tag, "_res"},   32'(bus.res),         32'h0);
    chk({tag, "_flags"}, 32'(bus.flags),       32'h0);
    chk({tag, "_rv"},    32'(bus.res_valid),   32'h0);
    chk({tag, "_err"},   32'(bus.err),         32'h0);
    chk({tag, "_busy"},  32'(bus.busy),        32'h0);
    chk({tag, "_n_ops"}, 32'(bus.n_ops),       32'h0);
    chk({tag, "_state"}, 32'(dut.state),       32'(ESPERA_A));
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.strobe  = 1'b1;
    bus.data_in = b;
    @(posedge clk);
    @(negedge clk);
    bus.strobe  = 1'b0;
  endtask

  int rv_cnt, err_cnt;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0, 5'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, ESPERA_B};
    tbl[1] = '{1'b1, 1'b0, 8'h01, 8'hFF, 8'h01, 3'd0, 5'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, ESPERA_CTRL};
    tbl[2] = '{1'b1, 1'b0, 8'h05, 8'hFF, 8'h01, 3'd0, 5'd5, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 8'd0, EJECUTA};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h01, 3'd0, 5'd5, 8'h00, 4'h9, 1'b1, 1'b0, 1'b0, 8'd1, LISTO};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h01, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, LISTO};
    tbl[5] = '{1'b1, 1'b0, 8'h10, 8'h10, 8'h01, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, ESPERA_B};
    tbl[6] = '{1'b1, 1'b0, 8'h20, 8'h10, 8'h20, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, ESPERA_CTRL};
    tbl[7] = '{1'b1, 1'b1, 8'h77, 8'h10, 8'h20, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, ESPERA_A};
    tbl[8] = '{1'b1, 1'b0, 8'h33, 8'h33, 8'h20, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, ESPERA_B};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 8'h33, 8'h20, 3'd0, 5'd5, 8'h00, 4'h9, 1'b0, 1'b0, 1'b0, 8'd1, ESPERA_A};

    bus.data_in = 8'h00; bus.strobe = 1'b0; bus.cancel = 1'b0;
    bus.alu_resultado = 8'h00;
    bus.alu_carry = 1'b1; bus.alu_overflow = 1'b0; bus.alu_negative = 1'b0; bus.alu_zero = 1'b1;

    // power-on reset
    #2 rst_n = 1'b0;
    #2 check_all_zero("por");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // table: first transaction (FF,01,05), then cancel-beats-strobe
    for (int i = 0; i < 10; i++) begin
      bus.strobe  = tbl[i].strobe;
      bus.cancel  = tbl[i].cancel;
      bus.data_in = tbl[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_op_a", i),  32'(bus.op_a),        32'(tbl[i].e_a));
      chk($sformatf("v%0d_op_b", i),  32'(bus.op_b),        32'(tbl[i].e_b));
      chk($sformatf("v%0d_ctrl", i),  32'(bus.op_control),  32'(tbl[i].e_ctrl));
      chk($sformatf("v%0d_cant", i),  32'(bus.op_cantidad), 32'(tbl[i].e_cant));
      chk($sformatf("v%0d_res", i),   32'(bus.res),         32'(tbl[i].e_res));
      chk($sformatf("v%0d_flags", i), 32'(bus.flags),       32'(tbl[i].e_flags));
      chk($sformatf("v%0d_rv", i),    32'(bus.res_valid),   32'(tbl[i].e_rv));
      chk($sformatf("v%0d_err", i),   32'(bus.err),         32'(tbl[i].e_err));
      chk($sformatf("v%0d_busy", i),  32'(bus.busy),        32'(tbl[i].e_busy));
      chk($sformatf("v%0d_n_ops", i), 32'(bus.n_ops),       32'(tbl[i].e_nops));
      chk($sformatf("v%0d_state", i), 32'(dut.state),       32'(tbl[i].e_st));
      @(negedge clk);
    end
    bus.strobe = 1'b0;
    bus.cancel = 1'b0;

    // timeout: A only, then idle for TO cycles
    bus.strobe = 1'b1; bus.data_in = 8'hAA;
    @(posedge clk); #1;
    chk("to_op_a", 32'(bus.op_a), 32'hAA);
    @(negedge clk);
    bus.strobe = 1'b0;
    for (int i = 1; i < TO; i++) begin
      @(posedge clk); #1;
      chk($sformatf("to_noerr%0d", i), 32'(bus.err), 32'h0);
      chk($sformatf("to_stB%0d", i), 32'(dut.state), 32'(ESPERA_B));
    end
    @(posedge clk); #1;
    chk("to_err", 32'(bus.err), 32'h1);
    chk("to_state", 32'(dut.state), 32'(ESPERA_A));
    chk("to_op_a_kept", 32'(bus.op_a), 32'hAA);
    @(posedge clk); #1;
    chk("to_err_pulse", 32'(bus.err), 32'h0);
    @(negedge clk);
    bus.strobe = 1'b1; bus.data_in = 8'h5C;
    @(posedge clk); #1;
    chk("to_next_a", 32'(bus.op_a), 32'h5C);
    chk("to_next_st", 32'(dut.state), 32'(ESPERA_B));
    @(negedge clk);
    bus.strobe = 1'b0; bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b0;

    // stray strobe during EJECUTA
    bus.alu_resultado = 8'h9C;
    bus.alu_carry = 1'b0; bus.alu_overflow = 1'b1; bus.alu_negative = 1'b1; bus.alu_zero = 1'b0;
    load_byte(8'h01);
    load_byte(8'h02);
    load_byte(8'h43);
    bus.strobe = 1'b1; bus.data_in = 8'hEE;
    @(posedge clk); #1;
    chk("ej_err", 32'(bus.err), 32'h1);
    chk("ej_rv", 32'(bus.res_valid), 32'h1);
    chk("ej_res", 32'(bus.res), 32'h9C);
    chk("ej_flags", 32'(bus.flags), 32'h6);
    chk("ej_n_ops", 32'(bus.n_ops), 32'd2);
    chk("ej_ctrl", 32'(bus.op_control), 32'd2);
    chk("ej_cant", 32'(bus.op_cantidad), 32'd3);
    chk("ej_state", 32'(dut.state), 32'(LISTO));
    chk("ej_op_a", 32'(bus.op_a), 32'h01);
    @(negedge clk);
    bus.strobe = 1'b0;
    @(posedge clk); #1;
    chk("ej_err_clr", 32'(bus.err), 32'h0);
    chk("ej_listo", 32'(dut.state), 32'(LISTO));
    chk("ej_op_a2", 32'(bus.op_a), 32'h01);
    @(negedge clk);

    // asynchronous reset in the middle of ESPERA_CTRL
    load_byte(8'h12);
    load_byte(8'h34);
    chk("rs_pre_a", 32'(bus.op_a), 32'h12);
    chk("rs_pre_b", 32'(bus.op_b), 32'h34);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 256 back-to-back transactions at minimum spacing
    rv_cnt = 0; err_cnt = 0;
    for (int t = 0; t < 256; t++) begin
      for (int k = 0; k < 4; k++) begin
        bus.strobe = (k < 3);
        bus.data_in = 8'($urandom);
        bus.alu_resultado = 8'($urandom);
        @(posedge clk); #1;
        if (bus.res_valid) rv_cnt++;
        if (bus.err) err_cnt++;
        @(negedge clk);
      end
    end
    bus.strobe = 1'b0;
    chk("b2b_n_ops", 32'(bus.n_ops), 32'd0);
    chk("b2b_rv_cnt", 32'(rv_cnt), 32'd256);
    chk("b2b_err_cnt", 32'(err_cnt), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      bus.strobe        = ($urandom_range(0, 99) < 55);
      bus.cancel        = ($urandom_range(0, 99) < 6);
      bus.data_in       = 8'($urandom);
      bus.alu_resultado = 8'($urandom);
      bus.alu_carry     = 1'($urandom);
      bus.alu_overflow  = 1'($urandom);
      bus.alu_negative  = 1'($urandom);
      bus.alu_zero      = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    bus.strobe = 1'b0;
    bus.cancel = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
